note_sequencer: RTL and testbench

- Plays one note per request: takes a 6-bit note code plus a duration and drives a square-wave speaker output for exactly that duration, then accepts the next request.
- Splits the note code by 12 internally into an octave index and a note-in-octave index.
- Selects the note divisor and octave prescale from those indices and counts half-periods.
- Sits between the song-ROM reader (upstream, valid/ready) and the speaker pin.

---
 rtl/note_sequencer.sv | 176 +++++++++++++++++
 tb/tb_note_sequencer.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/note_sequencer.sv
// note_sequencer: plays one note (or rest, code 63) per valid/ready request as a square wave.
// Build option NOTE_GAP_EN adds GAP_TICKS silent ticks after every non-zero-length note.
module note_sequencer #(
   parameter int TICK_DIV  = 25000,
   parameter int DUR_W     = 8,
   parameter int GAP_TICKS = 10
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             note_valid,
   output logic             note_ready,
   input  logic [5:0]       note_code,
   input  logic [DUR_W-1:0] note_dur,
   output logic             speaker,
   output logic             busy,
   output logic             done,
   output logic [2:0]       cur_octave,
   output logic [3:0]       cur_note,
   output logic [1:0]       fsm_state
);
   localparam int TW = $clog2(TICK_DIV);

   if (TICK_DIV < 2 || GAP_TICKS < 1) begin : g_bad_param
      $error("note_sequencer: TICK_DIV must be >= 2 and GAP_TICKS >= 1");
   end

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_PLAY = 2'd1,
      S_GAP  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic             accept;
   logic [TW-1:0]    tick_cnt;
   logic [DUR_W-1:0] dur_cnt;
   logic [8:0]       note_cnt;
   logic [7:0]       oct_cnt;
   logic             rest_q, speaker_q;
   logic             tick_wrap, play_end, note_exp, tone_edge;
   logic [2:0]       div_q;
   logic [1:0]       rem_hi;
   logic [3:0]       div_r;

   // Divisor minus one, so the note counter runs 0..D-1.
   function automatic logic [8:0] div_m1(input logic [3:0] r);
      case (r)
         4'd0:    return 9'd511;
         4'd1:    return 9'd482;
         4'd2:    return 9'd455;
         4'd3:    return 9'd430;
         4'd4:    return 9'd405;
         4'd5:    return 9'd383;
         4'd6:    return 9'd361;
         4'd7:    return 9'd341;
         4'd8:    return 9'd322;
         4'd9:    return 9'd303;
         4'd10:   return 9'd286;
         default: return 9'd270;
      endcase
   endfunction

   function automatic logic [7:0] pre_m1(input logic [2:0] q);
      return 8'((9'd256 >> q) - 9'd1);
   endfunction

   // code/12 == code[5:2]/3 because 12 = 3*4; the low two bits pass straight into the remainder.
   always_comb begin
      case (note_code[5:2])
         4'd0, 4'd1, 4'd2:    div_q = 3'd0;
         4'd3, 4'd4, 4'd5:    div_q = 3'd1;
         4'd6, 4'd7, 4'd8:    div_q = 3'd2;
         4'd9, 4'd10, 4'd11:  div_q = 3'd3;
         4'd12, 4'd13, 4'd14: div_q = 3'd4;
         default:             div_q = 3'd5;
      endcase
      rem_hi = 2'(note_code[5:2] - 4'(3 * div_q));
      div_r  = {rem_hi, note_code[1:0]};
   end

   // Handshake: a request transfers on the rising edge where note_valid && note_ready;
   // note_ready is high only in IDLE, and inputs are ignored on every other edge.
   assign accept    = note_valid && note_ready;
   assign tick_wrap = (tick_cnt == TW'(TICK_DIV - 1));
   assign play_end  = (state_q == S_PLAY) && tick_wrap && (dur_cnt == DUR_W'(1));
   assign note_exp  = (note_cnt == div_m1(cur_note));
   assign tone_edge = note_exp && (oct_cnt == 8'd0);

`ifdef NOTE_GAP_EN
   localparam int GW = $clog2(GAP_TICKS) + 1;
   logic [GW-1:0] gap_cnt;
   logic          gap_end;
   assign gap_end = tick_wrap && (gap_cnt == GW'(GAP_TICKS - 1));
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: if (accept) state_d = (note_dur == '0) ? S_DONE : S_PLAY;
`ifdef NOTE_GAP_EN
         S_PLAY: if (play_end) state_d = S_GAP;
         S_GAP:  if (gap_end)  state_d = S_DONE;
`else
         S_PLAY: if (play_end) state_d = S_DONE;
`endif
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      note_ready = rst_n && (state_q == S_IDLE);
      busy       = (state_q != S_IDLE);
      done       = (state_q == S_DONE);
   end

   assign speaker   = speaker_q;
   assign fsm_state = state_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cur_octave <= '0;
         cur_note   <= '0;
         rest_q     <= 1'b0;
         dur_cnt    <= '0;
         tick_cnt   <= '0;
         note_cnt   <= '0;
         oct_cnt    <= '0;
         speaker_q  <= 1'b0;
`ifdef NOTE_GAP_EN
         gap_cnt    <= '0;
`endif
      end else begin
         case (state_q)
            S_IDLE: if (accept) begin
               cur_octave <= div_q;
               cur_note   <= div_r;
               rest_q     <= &note_code;
               dur_cnt    <= note_dur;
               tick_cnt   <= '0;
               note_cnt   <= '0;
               oct_cnt    <= pre_m1(div_q);
`ifdef NOTE_GAP_EN
               gap_cnt    <= '0;
`endif
            end
            S_PLAY: begin
               tick_cnt <= tick_wrap ? '0 : tick_cnt + 1'b1;
               if (tick_wrap) dur_cnt <= dur_cnt - 1'b1;
               if (note_exp) begin
                  note_cnt <= '0;
                  oct_cnt  <= (oct_cnt == 8'd0) ? pre_m1(cur_octave) : oct_cnt - 1'b1;
               end else begin
                  note_cnt <= note_cnt + 1'b1;
               end
               // Leaving PLAY beats a coincident toggle so the pin always parks low.
               if (play_end)                    speaker_q <= 1'b0;
               else if (tone_edge && !rest_q)   speaker_q <= ~speaker_q;
            end
`ifdef NOTE_GAP_EN
            S_GAP: begin
               tick_cnt  <= tick_wrap ? '0 : tick_cnt + 1'b1;
               if (tick_wrap) gap_cnt <= gap_cnt + 1'b1;
               speaker_q <= 1'b0;
            end
`endif
            default: speaker_q <= 1'b0;
         endcase
      end
   end
endmodule

// File: tb/tb_note_sequencer.sv
// Bench for note_sequencer: instance a runs at TICK_DIV=8192, instance b at TICK_DIV=4.
module tb_note_sequencer;
   localparam int TICK_A = 8192;
   localparam int TICK_B = 4;
   localparam int GAP_T  = 1;
   localparam int EW     = 40;
`ifdef NOTE_GAP_EN
   localparam int GAP_ON = 1;
`else
   localparam int GAP_ON = 0;
`endif

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       valid [2];
   logic       ready [2];
   logic       speaker [2];
   logic       busy [2];
   logic       done [2];
   logic [5:0] code [2];
   logic [7:0] dur [2];
   logic [2:0] oct [2];
   logic [3:0] note [2];
   logic [1:0] st [2];

   int dtab [12] = '{512, 483, 456, 431, 406, 384, 362, 342, 323, 304, 287, 271};

   logic [EW-1:0] exp_q [$];
   int            tog_q [$];
   int            checks = 0;
   int            failures = 0;

   // monitor state
   int            cyc = 0;
   int            lat [2] = '{0, 0};
   int            ntog [2] = '{0, 0};
   int            done_cnt [2] = '{0, 0};
   int            play_exit [2] = '{0, 0};
   int            play_gap [2] = '{0, 0};
   int            hi_out_play [2] = '{0, 0};
   bit            run [2] = '{0, 0};
   bit            done_seen [2] = '{0, 0};
   logic          spk_prev [2] = '{1'b0, 1'b0};
   logic [1:0]    st_prev [2] = '{2'd0, 2'd0};
   logic [EW-1:0] obs_w [2];

   always #5 clk = ~clk;

   note_sequencer #(.TICK_DIV(TICK_A), .DUR_W(8), .GAP_TICKS(GAP_T)) dut_a (
      .clk(clk), .rst_n(rst_n), .note_valid(valid[0]), .note_ready(ready[0]),
      .note_code(code[0]), .note_dur(dur[0]), .speaker(speaker[0]), .busy(busy[0]),
      .done(done[0]), .cur_octave(oct[0]), .cur_note(note[0]), .fsm_state(st[0]));

   note_sequencer #(.TICK_DIV(TICK_B), .DUR_W(8), .GAP_TICKS(GAP_T)) dut_b (
      .clk(clk), .rst_n(rst_n), .note_valid(valid[1]), .note_ready(ready[1]),
      .note_code(code[1]), .note_dur(dur[1]), .speaker(speaker[1]), .busy(busy[1]),
      .done(done[1]), .cur_octave(oct[1]), .cur_note(note[1]), .fsm_state(st[1]));

   // Expected {octave, note, accept-to-done latency, toggles before done, speaker at done}.
   function automatic logic [EW-1:0] exp_word(input int c, input int d, input int tick);
      int oc, nt, h, l, lt, tg;
      oc = c / 12;
      nt = c % 12;
      h  = dtab[nt] * (256 >> oc);
      l  = d * tick;
      lt = 1 + l + ((d != 0) ? GAP_ON * GAP_T * tick : 0);
      tg = (c == 63 || d == 0) ? 0 : (l - 1) / h;
      return {3'(oc), 4'(nt), 24'(lt), 8'(tg), 1'b0};
   endfunction

   always @(negedge clk) begin
      cyc++;
      for (int i = 0; i < 2; i++) begin
         if (!rst_n) begin
            run[i] = 1'b0;
         end else begin
            if (run[i]) begin
               lat[i]++;
               if (done[i]) begin
                  obs_w[i]     = {oct[i], note[i], 24'(lat[i]), 8'(ntog[i]), speaker[i]};
                  done_seen[i] = 1'b1;
                  run[i]       = 1'b0;
               end else if (speaker[i] !== spk_prev[i]) begin
                  ntog[i]++;
                  if (i == 0) tog_q.push_back(lat[i]);
               end
            end
            if (valid[i] && ready[i]) begin
               run[i] = 1'b1; lat[i] = 0; ntog[i] = 0; done_seen[i] = 1'b0;
               if (i == 0) tog_q.delete();
            end
            if (done[i]) done_cnt[i]++;
            if (st[i] == 2'd1 && st_prev[i] != 2'd1) play_gap[i] = cyc - play_exit[i];
            if (st[i] != 2'd1 && st_prev[i] == 2'd1) play_exit[i] = cyc;
            if (busy[i] && st[i] != 2'd1 && speaker[i]) hi_out_play[i]++;
         end
         spk_prev[i] = speaker[i];
         st_prev[i]  = st[i];
      end
   end

   task automatic nclk();
      @(negedge clk);
      #1;
   endtask

   task automatic wait_ready(input int i);
      int n = 0;
      do begin
         nclk();
         n++;
      end while (ready[i] !== 1'b1 && n < 200);
      checks++;
      if (ready[i] !== 1'b1) begin
         failures++;
         $display("FAIL accept_wait inst=%0d ready=%b want=1", i, ready[i]);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input int i, input int c, input int d, input int tick, input bit hold);
      exp_q.push_back(exp_word(c, d, tick));
      @(posedge clk);
      #1;
      code[i]  = 6'(c);
      dur[i]   = 8'(d);
      valid[i] = 1'b1;
      wait_ready(i);
      if (!hold) valid[i] = 1'b0;
   endtask

   task automatic wait_done(input int i, input int budget, output bit ok);
      int n = 0;
      while (!done_seen[i] && n < budget) begin
         nclk();
         n++;
      end
      ok = done_seen[i];
      done_seen[i] = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      for (int i = 0; i < 2; i++) begin
         valid[i] = 1'b1; code[i] = 6'd60; dur[i] = 8'd3;
      end
      repeat (5) begin
         nclk();
         for (int i = 0; i < 2; i++) begin
            checks++;
            if ({speaker[i], busy[i], done[i]} !== 3'b000) begin
               failures++;
               $display("FAIL reset_hold inst=%0d spk/busy/done=%b want=000", i, {speaker[i], busy[i], done[i]});
            end
         end
      end
      @(posedge clk);
      #1;
      valid[0] = 1'b0; valid[1] = 1'b0;
      rst_n = 1'b1;
      nclk();
      for (int i = 0; i < 2; i++) begin
         checks++;
         if ({ready[i], busy[i], st[i], oct[i], note[i]} !== {1'b1, 1'b0, 2'd0, 3'd0, 4'd0}) begin
            failures++;
            $display("FAIL reset_release inst=%0d ready=%b busy=%b state=%0d oct=%0d note=%0d want 1 0 0 0 0",
                     i, ready[i], busy[i], st[i], oct[i], note[i]);
         end
      end
      checks++;
      if (done_cnt[0] + done_cnt[1] != 0) begin
         failures++;
         $display("FAIL reset_no_done got=%0d want=0", done_cnt[0] + done_cnt[1]);
      end
   endtask

   task automatic test_note();
      bit ok;
      logic [EW-1:0] w;
      drive(0, 60, 3, TICK_A, 1'b0);
      wait_done(0, 40000, ok);
      w = exp_q.pop_front();
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL note60_done no done pulse within budget, want word %h", w);
      end else if (obs_w[0] !== w) begin
         failures++;
         $display("FAIL note60_result got=%h want=%h", obs_w[0], w);
      end
      for (int k = 0; k < tog_q.size(); k++) begin
         checks++;
         if (tog_q[k] !== 1 + (k + 1) * 4096) begin
            failures++;
            $display("FAIL note60_toggle%0d at=%0d want=%0d", k, tog_q[k], 1 + (k + 1) * 4096);
         end
      end
   endtask

   task automatic test_rest_remainder();
      bit ok;
      logic [EW-1:0] w;
      drive(0, 63, 2, TICK_A, 1'b0);
      wait_done(0, 30000, ok);
      w = exp_q.pop_front();
      checks++;
      if (!ok || obs_w[0] !== w) begin
         failures++;
         $display("FAIL rest63_result done=%b got=%h want=%h", ok, obs_w[0], w);
      end
      drive(0, 62, 1, TICK_A, 1'b0);
      wait_done(0, 20000, ok);
      w = exp_q.pop_front();
      checks++;
      if (!ok || obs_w[0] !== w) begin
         failures++;
         $display("FAIL code62_result done=%b got=%h want=%h", ok, obs_w[0], w);
      end
      checks++;
      if (tog_q.size() == 0 || tog_q[0] !== 1 + 3648) begin
         failures++;
         $display("FAIL code62_half_period first_toggle=%0d want=%0d", (tog_q.size() == 0) ? -1 : tog_q[0], 1 + 3648);
      end
   endtask

   task automatic test_zero_dur();
      bit ok;
      logic [EW-1:0] w;
      drive(1, 10, 0, TICK_B, 1'b0);
      nclk();
      checks++;
      if ({done[1], speaker[1], ready[1]} !== 3'b100) begin
         failures++;
         $display("FAIL zero_dur_done done/spk/ready=%b want=100", {done[1], speaker[1], ready[1]});
      end
      nclk();
      checks++;
      if ({done[1], ready[1]} !== 2'b01) begin
         failures++;
         $display("FAIL zero_dur_ready done/ready=%b want=01", {done[1], ready[1]});
      end
      wait_done(1, 10, ok);
      w = exp_q.pop_front();
      checks++;
      if (!ok || obs_w[1] !== w) begin
         failures++;
         $display("FAIL zero_dur_result done=%b got=%h want=%h", ok, obs_w[1], w);
      end
   endtask

   task automatic test_reset_mid_play();
      int d0;
      drive(0, 60, 3, TICK_A, 1'b0);
      void'(exp_q.pop_back());
      repeat (4999) @(posedge clk);
      nclk();
      checks++;
      if (speaker[0] !== 1'b1) begin
         failures++;
         $display("FAIL midplay_speaker_high got=%b want=1", speaker[0]);
      end
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      d0 = done_cnt[0];
      nclk();
      checks++;
      if ({st[0], speaker[0], busy[0]} !== {2'd0, 1'b0, 1'b0}) begin
         failures++;
         $display("FAIL midplay_reset state=%0d spk=%b busy=%b want 0 0 0", st[0], speaker[0], busy[0]);
      end
      repeat (100) nclk();
      checks++;
      if (done_cnt[0] != d0 || ready[0] !== 1'b1) begin
         failures++;
         $display("FAIL midplay_no_done done_pulses=%0d want=0 ready=%b", done_cnt[0] - d0, ready[0]);
      end
   endtask

   task automatic test_back_to_back();
      bit ok;
      logic [EW-1:0] w;
      int hi0;
      hi0 = hi_out_play[1];
      exp_q.push_back(exp_word(5, 1, TICK_B));
      exp_q.push_back(exp_word(40, 1, TICK_B));
      @(posedge clk);
      #1;
      code[1] = 6'd5; dur[1] = 8'd1; valid[1] = 1'b1;
      wait_ready(1);
      code[1] = 6'd40;
      for (int k = 0; k < 2; k++) begin
         wait_done(1, 50, ok);
         w = exp_q.pop_front();
         checks++;
         if (!ok || obs_w[1] !== w) begin
            failures++;
            $display("FAIL b2b_result%0d done=%b got=%h want=%h", k, ok, obs_w[1], w);
         end
         if (k == 0) begin
            wait_ready(1);
            valid[1] = 1'b0;
         end
      end
      checks++;
      if (play_gap[1] != (GAP_ON ? 6 : 2)) begin
         failures++;
         $display("FAIL b2b_gap got=%0d want=%0d", play_gap[1], GAP_ON ? 6 : 2);
      end
      checks++;
      if (hi_out_play[1] != hi0) begin
         failures++;
         $display("FAIL b2b_silent speaker_high_cycles=%0d want=0", hi_out_play[1] - hi0);
      end
   endtask

   task automatic test_random();
      bit ok;
      logic [EW-1:0] w;
      int c, d;
      for (int k = 0; k < 12; k++) begin
         c = $urandom_range(0, 63);
         d = $urandom_range(0, 15);
         drive(1, c, d, TICK_B, 1'b0);
         wait_done(1, 200, ok);
         w = exp_q.pop_front();
         checks++;
         if (!ok || obs_w[1] !== w) begin
            failures++;
            $display("FAIL random%0d code=%0d dur=%0d done=%b got=%h want=%h", k, c, d, ok, obs_w[1], w);
         end
      end
   endtask

   initial begin
      #50_000_000;
      $display("FAIL watchdog simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      valid[0] = 1'b0; valid[1] = 1'b0;
      code[0] = '0; code[1] = '0;
      dur[0] = '0; dur[1] = '0;
      test_reset();
      test_note();
      test_rest_remainder();
      test_zero_dur();
      test_reset_mid_play();
      test_back_to_back();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
